irq_ctrl: RTL and testbench

Interrupt controller that sits between the peripherals and the CPU core's `IRQ` input. It has eight channels. For each channel it synchronises and qualifies the peripheral request as a level or a rising edge, and latches edge events into a pending register. It drives `IRQ` with the enabled pending set. Software configures and acknowledges channels through a four-register bus slave on the standard `cs_`/`as_`/`rdy_` handshake.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_chan.sv | 71 +++++++
 rtl/irq_ctrl.sv | 138 +++++++++++++
 tb/tb_irq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: channel count, bus width, register map, FSM and mode encodings.
// No logic; pure definitions.
// No flow control.
package irq_ctrl_pkg;

    localparam int CPU_IRQ_CH  = 8;
    localparam int WORD_DATA_W = 32;
    localparam int IRQ_ADDR_W  = 2;

    localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_PEND   = 2'd0;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_ENABLE = 2'd1;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_MODE   = 2'd2;
    localparam logic [IRQ_ADDR_W-1:0] IRQ_ADDR_RAW    = 2'd3;

    typedef enum logic {
        IRQ_STATE_IDLE = 1'b0,
        IRQ_STATE_ACK  = 1'b1
    } irq_state_e;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_chan.sv
// One interrupt channel: optional 2-flop synchroniser (IRQ_CTRL_SYNC_EN), edge detector and pending bit.
// Latency: pend updates on the edge after s changes; the synchroniser adds 2 edges in front of s.
// No backpressure; W1C clear and mode-change clear are single-cycle strobes.
module irq_chan
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_,
    input  logic src,
    input  logic mode,
    input  logic clr,
    input  logic mode_chg,
    output logic s,
    output logic pend
);

`ifdef IRQ_CTRL_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = src;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = src;
`endif

    logic s_dly_q, s_dly_d;
    logic pend_q, pend_d;

    // A fresh edge beats a same-cycle software clear so no event is lost.
    always_comb begin
        s_dly_d = s;
        pend_d  = pend_q;
        if (mode_chg) begin
            pend_d = 1'b0;
        end else if (mode == IRQ_MODE_LEVEL) begin
            pend_d = s;
        end else if (s && !s_dly_q) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            s_dly_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            s_dly_q <= s_dly_d;
            pend_q  <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: IRQ_CH channels, 4-register bus slave, registered IRQ = Pend & Enable, lowest-index priority id.
// Latency: bus access 1 cycle (Rdy_ low E0..E1); source to IRQ 2 edges, 4 with IRQ_CTRL_SYNC_EN.
// No backpressure; strobes arriving while ACK is held are dropped, masters wait for Rdy_.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int IRQ_CH = CPU_IRQ_CH,
    parameter int DATA_W = WORD_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [IRQ_CH-1:0]     SrcReq,
    input  logic                  CS_,
    input  logic                  AS_,
    input  logic                  RW,
    input  logic [IRQ_ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     RdData,
    output logic                  Rdy_,
    output logic [IRQ_CH-1:0]     IRQ,
    output logic [2:0]            IrqId,
    output logic                  IrqAny
);

    irq_state_e state_q, state_d;
    logic                rdy_n_q, rdy_n_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [IRQ_CH-1:0]   enable_q, enable_d;
    logic [IRQ_CH-1:0]   mode_q, mode_d;
    logic [IRQ_CH-1:0]   irq_q, irq_d;

    logic [IRQ_CH-1:0]   pend;
    logic [IRQ_CH-1:0]   s;
    logic [IRQ_CH-1:0]   clr;
    logic [IRQ_CH-1:0]   mode_chg;
    logic [IRQ_CH-1:0]   wr_ch;
    logic [DATA_W-1:0]   rd_mux;
    logic                acc;
    logic                wr_acc;
    logic                rd_acc;
    logic [2:0]          irq_id;
    logic                unused_wr_hi;

    assign wr_ch        = WrData[IRQ_CH-1:0];
    assign unused_wr_hi = &{1'b0, WrData[DATA_W-1:IRQ_CH]};

    for (genvar i = 0; i < IRQ_CH; i++) begin : g_chan
        irq_chan u_chan (
            .clk      (clk),
            .reset_   (reset_),
            .src      (SrcReq[i]),
            .mode     (mode_q[i]),
            .clr      (clr[i]),
            .mode_chg (mode_chg[i]),
            .s        (s[i]),
            .pend     (pend[i])
        );
    end

    always_comb begin
        acc      = (state_q == IRQ_STATE_IDLE) && !CS_ && !AS_;
        wr_acc   = acc && !RW;
        rd_acc   = acc && RW;
        clr      = '0;
        mode_chg = '0;
        enable_d = enable_q;
        mode_d   = mode_q;
        if (wr_acc) begin
            case (Addr)
                IRQ_ADDR_PEND:   clr = wr_ch;
                IRQ_ADDR_ENABLE: enable_d = wr_ch;
                IRQ_ADDR_MODE: begin
                    mode_d   = wr_ch;
                    mode_chg = wr_ch ^ mode_q;
                end
                default: ;
            endcase
        end
    end

    // PEND reads sample pend before this edge's set/clear lands.
    always_comb begin
        rd_mux = '0;
        case (Addr)
            IRQ_ADDR_PEND:   rd_mux[IRQ_CH-1:0] = pend;
            IRQ_ADDR_ENABLE: rd_mux[IRQ_CH-1:0] = enable_q;
            IRQ_ADDR_MODE:   rd_mux[IRQ_CH-1:0] = mode_q;
            default:         rd_mux[IRQ_CH-1:0] = s;
        endcase
    end

    always_comb begin
        state_d   = acc ? IRQ_STATE_ACK : IRQ_STATE_IDLE;
        rdy_n_d   = !acc;
        rd_data_d = rd_acc ? rd_mux : '0;
        irq_d     = pend & enable_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= IRQ_STATE_IDLE;
            rdy_n_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rdy_n_q   <= rdy_n_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            enable_q <= '0;
            mode_q   <= '0;
            irq_q    <= '0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        irq_id = 3'd0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (irq_q[i]) begin
                irq_id = 3'(i);
            end
        end
    end

    assign RdData = rd_data_q;
    assign Rdy_   = rdy_n_q;
    assign IRQ    = irq_q;
    assign IrqId  = irq_id;
    assign IrqAny = |irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: table of level/priority vectors plus hand sequences for edge, W1C, collision, bus and reset.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_;
    logic [7:0]  SrcReq;
    logic        CS_;
    logic        AS_;
    logic        RW;
    logic [1:0]  Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Rdy_;
    logic [7:0]  IRQ;
    logic [2:0]  IrqId;
    logic        IrqAny;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl dut (
        .clk    (clk),
        .reset_ (reset_),
        .SrcReq (SrcReq),
        .CS_    (CS_),
        .AS_    (AS_),
        .RW     (RW),
        .Addr   (Addr),
        .WrData (WrData),
        .RdData (RdData),
        .Rdy_   (Rdy_),
        .IRQ    (IRQ),
        .IrqId  (IrqId),
        .IrqAny (IrqAny)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] src;
        logic [7:0] en;
        logic [7:0] exp_irq;
        logic [2:0] exp_id;
        logic       exp_any;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the ACK cycle.
    task automatic bus(input logic rw, input logic [1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        CS_ = 1'b0; AS_ = 1'b0; RW = rw; Addr = a; WrData = wd;
        tick(1);
        chk("bus_rdy_low", Rdy_, 1'b0);
        rd = RdData;
        CS_ = 1'b1; AS_ = 1'b1; RW = 1'b1; WrData = '0;
        tick(1);
        chk("bus_rdy_high", Rdy_, 1'b1);
        chk("bus_rddata_idle", RdData, 32'h0);
    endtask

    logic [31:0] rd;

    initial begin
        vecs[0] = '{src: 8'h01, en: 8'h01, exp_irq: 8'h01, exp_id: 3'd0, exp_any: 1'b1};
        vecs[1] = '{src: 8'h00, en: 8'h01, exp_irq: 8'h00, exp_id: 3'd0, exp_any: 1'b0};
        vecs[2] = '{src: 8'hA4, en: 8'hFF, exp_irq: 8'hA4, exp_id: 3'd2, exp_any: 1'b1};
        vecs[3] = '{src: 8'hA4, en: 8'hA0, exp_irq: 8'hA0, exp_id: 3'd5, exp_any: 1'b1};
        vecs[4] = '{src: 8'h80, en: 8'hFF, exp_irq: 8'h80, exp_id: 3'd7, exp_any: 1'b1};
        vecs[5] = '{src: 8'hFF, en: 8'h00, exp_irq: 8'h00, exp_id: 3'd0, exp_any: 1'b0};
        vecs[6] = '{src: 8'h5A, en: 8'h18, exp_irq: 8'h18, exp_id: 3'd3, exp_any: 1'b1};

        // Reset with all sources high
        reset_ = 1'b0; SrcReq = 8'hFF; CS_ = 1'b1; AS_ = 1'b1; RW = 1'b1; Addr = 2'd0; WrData = '0;
        tick(2);
        chk("rst_irq", IRQ, 8'h00);
        chk("rst_rdy", Rdy_, 1'b1);
        chk("rst_rddata", RdData, 32'h0);
        chk("rst_irqany", IrqAny, 1'b0);
        chk("rst_irqid", IrqId, 3'd0);
        reset_ = 1'b1; SrcReq = 8'h00;
        tick(1);
        bus(1'b1, 2'd0, '0, rd); chk("rst_pend_rd", rd, 32'h0);
        bus(1'b1, 2'd1, '0, rd); chk("rst_enable_rd", rd, 32'h0);
        bus(1'b1, 2'd2, '0, rd); chk("rst_mode_rd", rd, 32'h0);

        // Level channel latency and ignored W1C
        bus(1'b0, 2'd1, 32'h01, rd);
        SrcReq = 8'h01;
        tick(1 + SYNC_LAT);
        chk("lvl_rise_early", IRQ, 8'h00);
        tick(1);
        chk("lvl_rise_irq", IRQ, 8'h01);
        SrcReq = 8'h00;
        tick(1 + SYNC_LAT);
        chk("lvl_fall_early", IRQ, 8'h01);
        tick(1);
        chk("lvl_fall_irq", IRQ, 8'h00);
        SrcReq = 8'h01;
        tick(3 + SYNC_LAT);
        bus(1'b0, 2'd0, 32'h01, rd);
        chk("lvl_w1c_irq", IRQ, 8'h01);
        bus(1'b1, 2'd0, '0, rd); chk("lvl_w1c_pend", rd, 32'h01);
        SrcReq = 8'h00;
        tick(3 + SYNC_LAT);

        // Edge channel capture and W1C
        bus(1'b0, 2'd2, 32'h08, rd);
        bus(1'b0, 2'd1, 32'h08, rd);
        tick(2);
        SrcReq = 8'h08;
        tick(1);
        SrcReq = 8'h00;
        tick(2 + SYNC_LAT);
        chk("edge_irq", IRQ, 8'h08);
        chk("edge_irqid", IrqId, 3'd3);
        chk("edge_irqany", IrqAny, 1'b1);
        bus(1'b1, 2'd0, '0, rd); chk("edge_pend", rd, 32'h08);
        bus(1'b0, 2'd0, 32'h08, rd);
        chk("edge_w1c_irq", IRQ, 8'h00);
        bus(1'b1, 2'd0, '0, rd); chk("edge_w1c_pend", rd, 32'h00);

        // New rising edge on the same edge as the W1C
        SrcReq = 8'h08;
        tick(1);
        SrcReq = 8'h00;
        tick(3 + SYNC_LAT);
        SrcReq = 8'h08;
        tick(SYNC_LAT);
        bus(1'b0, 2'd0, 32'h08, rd);
        chk("collide_irq", IRQ, 8'h08);
        bus(1'b1, 2'd0, '0, rd); chk("collide_pend", rd, 32'h08);
        SrcReq = 8'h00;
        tick(3 + SYNC_LAT);

        // Mode change clears pending even while the source stays high
        bus(1'b0, 2'd2, 32'h00, rd);
        SrcReq = 8'h08;
        tick(3 + SYNC_LAT);
        bus(1'b1, 2'd0, '0, rd); chk("modechg_pre_pend", rd, 32'h08);
        bus(1'b0, 2'd2, 32'h08, rd);
        bus(1'b1, 2'd0, '0, rd); chk("modechg_pend", rd, 32'h00);
        SrcReq = 8'h00;
        bus(1'b0, 2'd2, 32'h00, rd);

        // Level/priority table
        for (int i = 0; i < 7; i++) begin
            bus(1'b0, 2'd1, {24'h0, vecs[i].en}, rd);
            SrcReq = vecs[i].src;
            tick(3 + SYNC_LAT);
            chk($sformatf("vec%0d_irq", i), IRQ, vecs[i].exp_irq);
            chk($sformatf("vec%0d_irqid", i), IrqId, vecs[i].exp_id);
            chk($sformatf("vec%0d_irqany", i), IrqAny, vecs[i].exp_any);
            bus(1'b1, 2'd3, '0, rd); chk($sformatf("vec%0d_raw", i), rd, {24'h0, vecs[i].src});
            bus(1'b1, 2'd0, '0, rd); chk($sformatf("vec%0d_pend", i), rd, {24'h0, vecs[i].src});
        end

        // RAW read and a second strobe held through ACK
        SrcReq = 8'h5A;
        tick(2 + SYNC_LAT);
        bus(1'b1, 2'd3, '0, rd); chk("raw_rd", rd, 32'h0000005A);
        CS_ = 1'b0; AS_ = 1'b0; RW = 1'b1; Addr = 2'd3;
        tick(1);
        chk("dbl_rdy_low", Rdy_, 1'b0);
        chk("dbl_rddata", RdData, 32'h0000005A);
        Addr = 2'd1;
        tick(1);
        chk("dbl_ignored_rdy", Rdy_, 1'b1);
        chk("dbl_ignored_rddata", RdData, 32'h0);
        CS_ = 1'b1; AS_ = 1'b1;
        tick(1);
        chk("dbl_after_rdy", Rdy_, 1'b1);

        // Reset asserted during ACK
        bus(1'b0, 2'd1, 32'hFF, rd);
        SrcReq = 8'hFF;
        tick(3 + SYNC_LAT);
        chk("pre_rst_irq", IRQ, 8'hFF);
        CS_ = 1'b0; AS_ = 1'b0; RW = 1'b1; Addr = 2'd2;
        tick(1);
        chk("ackrst_rdy_low", Rdy_, 1'b0);
        reset_ = 1'b0; CS_ = 1'b1; AS_ = 1'b1;
        tick(1);
        chk("ackrst_rdy", Rdy_, 1'b1);
        chk("ackrst_rddata", RdData, 32'h0);
        chk("ackrst_irq", IRQ, 8'h00);
        reset_ = 1'b1; SrcReq = 8'h00;
        tick(1);
        bus(1'b1, 2'd1, '0, rd); chk("ackrst_enable_rd", rd, 32'h0);
        bus(1'b1, 2'd0, '0, rd); chk("ackrst_pend_rd", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
